// File: rtl/cascade_delays_ctrl.sv
// Slew sequencer and calibration sweep for the cascade_delays line.
// Code moves one unit per settle interval; select is registered alongside cur_code.
module cascade_delays_ctrl #(
    parameter int Nmbr_cascades = 4,
    parameter int SETTLE_CYCLES = 4,
    localparam int CW = $clog2(2*Nmbr_cascades+1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [CW-1:0]              cfg_code,
    input  logic                       cal_start,
    input  logic                       pd_early,
    output logic [2*Nmbr_cascades-1:0] select,
    output logic [CW-1:0]              cur_code,
    output logic                       busy,
    output logic                       cal_done,
    output logic                       cal_fail
);
    localparam logic [CW-1:0] MAX_CODE = CW'(2*Nmbr_cascades);
    localparam int TW = $clog2(SETTLE_CYCLES+1);

    typedef enum logic [1:0] {IDLE, SLEW, CAL_SETTLE, CAL_EVAL} state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              cur_code_q, cur_code_d;
    logic [CW-1:0]              target_q, target_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic [2*Nmbr_cascades-1:0] select_q;
    logic                       cal_done_q, cal_done_d;
    logic                       cal_fail_q, cal_fail_d;
    logic                       pd_meta_q, pd_sync_q;
    logic [CW-1:0]              clamped;

    function automatic logic [2*Nmbr_cascades-1:0] decode(input logic [CW-1:0] code);
        logic [2*Nmbr_cascades-1:0] sel;
        sel = '0;
        for (int unsigned i = 0; i < Nmbr_cascades; i++) begin
            if (32'(code) >= 2*i+2)
                sel[2*i +: 2] = 2'b10;
            else if (32'(code) == 2*i+1)
                sel[2*i +: 2] = 2'b01;
        end
        return sel;
    endfunction

    assign clamped   = (cfg_code > MAX_CODE) ? MAX_CODE : cfg_code;
    assign cfg_ready = (state_q == IDLE) && !cal_start;
    assign select    = select_q;
    assign cur_code  = cur_code_q;
    assign busy      = (state_q != IDLE);
    assign cal_done  = cal_done_q;
    assign cal_fail  = cal_fail_q;

    always_comb begin
        state_d    = state_q;
        cur_code_d = cur_code_q;
        target_d   = target_q;
        timer_d    = timer_q;
        cal_done_d = 1'b0;
        cal_fail_d = cal_fail_q;
        unique case (state_q)
            IDLE: begin
                if (cal_start) begin
                    state_d    = CAL_SETTLE;
                    cur_code_d = '0;
                    timer_d    = TW'(SETTLE_CYCLES);
                    cal_fail_d = 1'b0;
                end else if (cfg_valid) begin
                    cal_fail_d = 1'b0;
                    target_d   = clamped;
                    if (clamped != cur_code_q) begin
                        state_d = SLEW;
                        timer_d = '0;
                    end
                end
            end
            SLEW: begin
                // Timer starts at 0 so the first step lands on the edge after acceptance.
                if (timer_q == '0) begin
                    if (cur_code_q == target_q) begin
                        state_d = IDLE;
                    end else begin
                        cur_code_d = (cur_code_q < target_q) ? cur_code_q + CW'(1)
                                                             : cur_code_q - CW'(1);
                        timer_d    = TW'(SETTLE_CYCLES-1);
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            CAL_SETTLE: begin
                if (timer_q == '0)
                    state_d = CAL_EVAL;
                else
                    timer_d = timer_q - TW'(1);
            end
            CAL_EVAL: begin
                if (!pd_sync_q) begin
                    state_d    = IDLE;
                    cal_done_d = 1'b1;
                    cal_fail_d = (cur_code_q == '0);
                end else if (cur_code_q == MAX_CODE) begin
                    state_d    = IDLE;
                    cal_done_d = 1'b1;
                    cal_fail_d = 1'b1;
                end else begin
                    state_d    = CAL_SETTLE;
                    cur_code_d = cur_code_q + CW'(1);
                    timer_d    = TW'(SETTLE_CYCLES);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_code_q <= '0;
            target_q   <= '0;
            timer_q    <= '0;
            select_q   <= '0;
            cal_done_q <= 1'b0;
            cal_fail_q <= 1'b0;
            pd_meta_q  <= 1'b0;
            pd_sync_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_code_q <= cur_code_d;
            target_q   <= target_d;
            timer_q    <= timer_d;
            select_q   <= decode(cur_code_d);
            cal_done_q <= cal_done_d;
            cal_fail_q <= cal_fail_d;
            pd_meta_q  <= pd_early;
            pd_sync_q  <= pd_meta_q;
        end
    end
endmodule

// File: tb/tb_cascade_delays_ctrl.sv
// Bench for cascade_delays_ctrl: directed steps plus random slews and sweeps
// checked against an arithmetic model of the code trajectory.
module tb_cascade_delays_ctrl;
    localparam int N    = 4;
    localparam int S    = 4;
    localparam int CW   = 4;
    localparam int MAXC = 8;

    logic          clk = 1'b0;
    logic          rst_n, cfg_valid, cal_start, pd_early;
    logic [CW-1:0] cfg_code, cur_code;
    logic [2*N-1:0] select;
    logic          cfg_ready, busy, cal_done, cal_fail;

    int total  = 0;
    int passed = 0;
    int pd_thresh;
    int m_code;
    logic m_fail;

    always #5 clk = ~clk;

    // Phase detector stand-in: edge stays early while the code is below the threshold.
    assign pd_early = (int'(cur_code) < pd_thresh);

    cascade_delays_ctrl #(.Nmbr_cascades(N), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_code(cfg_code), .cal_start(cal_start), .pd_early(pd_early),
        .select(select), .cur_code(cur_code), .busy(busy),
        .cal_done(cal_done), .cal_fail(cal_fail)
    );

    function automatic logic [7:0] ref_sel(input int code);
        logic [7:0] r;
        int u;
        r = '0;
        for (int i = 0; i < N; i++) begin
            u = code - 2*i;
            if (u < 0) u = 0;
            if (u > 2) u = 2;
            r[2*i +: 2] = 2'(u);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_select"}, select, 0);
        check({tag, "_code"}, cur_code, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, cal_done, 0);
        check({tag, "_fail"}, cal_fail, 0);
    endtask

    // Called at a negedge with the block idle.
    task automatic do_slew(input int req);
        int tgt, d, steps, tot, start, k, e_code;
        tgt   = (req > MAXC) ? MAXC : req;
        start = m_code;
        d     = tgt - start;
        steps = (d < 0) ? -d : d;
        tot   = steps*S + 1;
        check("slew_ready_before", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_code  = CW'(req);
        @(negedge clk);
        cfg_valid = 1'b0;
        m_fail    = 1'b0;
        check("slew_fail_cleared", cal_fail, 0);
        check("slew_busy_after_accept", busy, (steps != 0));
        if (steps == 0) begin
            check("slew_zero_code", cur_code, start);
            check("slew_zero_ready", cfg_ready, 1);
        end else begin
            for (int e = 1; e <= tot; e++) begin
                @(negedge clk);
                k      = (e-1)/S + 1;
                if (k > steps) k = steps;
                e_code = (d > 0) ? start + k : start - k;
                check("slew_code", cur_code, e_code);
                check("slew_select", select, ref_sel(e_code));
                check("slew_ready", cfg_ready, (e == tot));
                if (e < tot-1) begin
                    cfg_valid = 1'($urandom);
                    cal_start = 1'($urandom);
                    cfg_code  = CW'($urandom);
                end else begin
                    cfg_valid = 1'b0;
                    cal_start = 1'b0;
                end
            end
        end
        m_code = tgt;
    endtask

    task automatic do_cal(input int thr);
        int  e_code;
        logic e_fail, seen;
        pd_thresh = thr;
        if (thr <= 0) begin
            e_code = 0; e_fail = 1'b1;
        end else if (thr > MAXC) begin
            e_code = MAXC; e_fail = 1'b1;
        end else begin
            e_code = thr; e_fail = 1'b0;
        end
        cal_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_code  = CW'($urandom_range(0, 15));
        #1;
        check("cal_start_blocks_ready", cfg_ready, 0);
        @(negedge clk);
        cal_start = 1'b0;
        check("cal_busy", busy, 1);
        check("cal_code_zero", cur_code, 0);
        check("cal_fail_cleared", cal_fail, 0);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (cal_done) seen = 1'b1;
        end
        cfg_valid = 1'b0;
        check("cal_done_seen", seen, 1);
        check("cal_end_code", cur_code, e_code);
        check("cal_end_fail", cal_fail, e_fail);
        check("cal_end_select", select, ref_sel(e_code));
        check("cal_end_busy", busy, 0);
        @(negedge clk);
        check("cal_done_single", cal_done, 0);
        check("cal_code_hold", cur_code, e_code);
        m_code = e_code;
        m_fail = e_fail;
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals(tag);
        cfg_valid = 1'b0;
        cal_start = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        m_code = 0;
        m_fail = 1'b0;
        @(negedge clk);
        check_reset_vals({tag, "_post"});
        check({tag, "_ready"}, cfg_ready, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic reached;
        rst_n = 1'b0; cfg_valid = 1'b0; cal_start = 1'b0; cfg_code = '0;
        pd_thresh = 0; m_code = 0; m_fail = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_rel");
        check("rst_ready", cfg_ready, 1);

        do_slew(3);
        check("slew3_select", select, 8'h06);
        do_slew(12);
        check("clamp_select", select, 8'hAA);
        do_slew(5);
        check("slew5_select", select, 8'h1A);

        do_cal(5);
        check("cal5_select", select, 8'h1A);
        do_cal(100);
        check("cal_hi_code", cur_code, 8);
        do_cal(0);
        do_slew(4);
        check("fail_cleared_by_cfg", cal_fail, 0);

        do_slew(0);
        cfg_valid = 1'b1;
        cfg_code  = 4'd6;
        @(negedge clk);
        cfg_valid = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 20 && !reached; c++) begin
            if (cur_code == 4'd2) reached = 1'b1;
            else @(negedge clk);
        end
        check("mid_slew_reached2", reached, 1);
        async_reset("rst_slew");
        do_slew(7);

        pd_thresh = 100;
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_cal_busy", busy, 1);
        async_reset("rst_cal");
        do_slew(2);

        repeat (12) begin
            if ($urandom_range(0, 1) == 1) do_slew($urandom_range(0, 15));
            else do_cal($urandom_range(0, 10));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cascade_delays_ctrl.md
Name: cascade_delays_ctrl

Overview:
Sequencer and calibrator for the cascade_delays line. It drives the packed per-stage select word from a scalar delay code, and moves between codes one unit at a time with a settle interval per step so the delayed signal never sees a multi-stage jump. It also runs a calibration sweep that finds the first code at which an external phase detector stops reporting "early". It sits in the clocked control domain directly beside the delay cascade.

Parameters:
Nmbr_cascades, `Nmbr_cascades (4), number of delay stages; must match the driven cascade.
SETTLE_CYCLES, 4, clock cycles each code is held before the next step or sample; minimum 3.
CW, $clog2(2*Nmbr_cascades+1), localparam, delay-code width.
MAX_CODE, 2*Nmbr_cascades, localparam, largest legal code.

Ports:
clk  in  1  control clock.
rst_n  in  1  asynchronous active-low reset.
cfg_valid  in  1  manual code request valid.
cfg_ready  out  1  request accepted when cfg_valid&&cfg_ready; equals (state==IDLE)&&!cal_start.
cfg_code  in  CW  requested delay code; values above MAX_CODE are clamped to MAX_CODE.
cal_start  in  1  starts a calibration sweep; sampled only in IDLE.
pd_early  in  1  asynchronous phase-detector flag; 1 = delayed edge is still early.
select  out  2*Nmbr_cascades  select bus to the cascade; stage i uses bits [2i+1:2i].
cur_code  out  CW  code currently applied.
busy  out  1  high in every state except IDLE.
cal_done  out  1  one-cycle pulse when a sweep ends.
cal_fail  out  1  sweep found no transition; held until the next cal_start or cfg acceptance.

Behaviour:
- Code-to-select decode: stage i = min(2, max(0, code-2i)). Encodings are 2'b00 = 0 units, 2'b01 = 1 unit, 2'b10 = 2 units. 2'b11 is never driven. Stages fill from stage 0.
- select is a register loaded on the same edge as cur_code, from the decode of the next code. No combinational path exists from state to select.
- Reset (rst_n low, asynchronous, may occur in any state):
  - state=IDLE; cur_code=0; select=0; busy=0; cal_done=0; cal_fail=0.
  - The pd_early synchronizer is cleared.
  - Any slew or sweep in progress is abandoned. No resume.
- pd_early passes through a 2-flop synchronizer. All decisions use the synchronized value.
- States: IDLE, SLEW, CAL_SETTLE, CAL_EVAL.
- IDLE:
  - cal_start=1: go to CAL_SETTLE. cur_code jumps directly to 0 on that edge. Timer loads SETTLE_CYCLES. cal_fail clears.
  - Otherwise, cfg accepted: clamp the code into target and clear cal_fail.
    - target==cur_code: remain in IDLE (zero-cycle request).
    - Else go to SLEW.
  - If cal_start and cfg_valid are both high, cal_start wins and cfg_ready is 0 that cycle.
- SLEW:
  - cur_code moves ±1 toward target on the first edge after acceptance, then again every SETTLE_CYCLES edges.
  - After the final change, the block holds SETTLE_CYCLES edges and then returns to IDLE.
  - Accept to cfg_ready high = |delta|*SETTLE_CYCLES+1 edges.
  - New cfg and cal_start are ignored during SLEW.
- CAL_SETTLE: timer counts down. At 0, go to CAL_EVAL.
- CAL_EVAL (one cycle), using synced pd_early:
  - pd=0 and cur_code==0: cal_fail=1, cal_done pulse, go to IDLE; code stays 0.
  - pd=0 and cur_code>0: cal_done pulse, go to IDLE; code stays at cur_code.
  - pd=1 and cur_code==MAX_CODE: cal_fail=1, cal_done pulse, go to IDLE; code stays MAX_CODE.
  - pd=1 otherwise: cur_code+1, reload timer, go to CAL_SETTLE.
- cal_done is high for exactly one cycle, asserted on the edge that enters IDLE.
- cur_code never exceeds MAX_CODE and never wraps.

Test Plan:
1. Reset: hold rst_n=0, then release; drive no cfg_valid and no cal_start -> select=8'h00, cur_code=0, busy=0, cal_done=0, cal_fail=0, cfg_ready=1.
2. From code 0, accept cfg_code=3 (N=4, S=4) -> select=8'h01 at edge 1, 8'h02 at edge 5, 8'h06 at edge 9; cfg_ready returns high at edge 13; select never equals 8'h03 or 8'h07.
3. Accept cfg_code=12 -> clamps to 8, final select=8'hAA. Then accept cfg_code=5 -> cur_code steps 7, 6, 5 each 4 cycles apart; final select=8'h1A.
4. Sweep with pd_early=1 until cur_code reaches 5, then 0 -> cal_done pulses once, cal_fail=0, cur_code=5, select=8'h1A. Assert cfg_valid during the sweep -> it is not accepted.
5. Sweep with pd_early stuck at 1 -> sweep ends at cur_code=8, cal_fail=1. Sweep with pd_early stuck at 0 -> ends at code 0, cal_fail=1. Then accept a cfg request -> cal_fail clears.
6. Pull rst_n low mid-SLEW (cur_code=2, target 6) and mid-CAL_SETTLE -> outputs go to reset values immediately, without waiting for a clk edge. After release, the block is in IDLE and a new cfg request completes normally.
